// File: rtl/ctrl_pkg.sv
// ctrl_pkg: opcode, ALU-op and state definitions shared by the multicycle controller.
package ctrl_pkg;
    localparam logic [3:0] OP_ADD   = 4'b0000;
    localparam logic [3:0] OP_SUB   = 4'b0001;
    localparam logic [3:0] OP_LOAD  = 4'b0010;
    localparam logic [3:0] OP_STORE = 4'b0011;
    localparam logic [3:0] OP_JUMP  = 4'b0100;
    localparam logic [3:0] OP_BEQ   = 4'b0101;
    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB} state_e;
endpackage

// File: rtl/ctrl_wait_timer.sv
// ctrl_wait_timer: counts memory wait cycles and flags expiry one step before saturation.
module ctrl_wait_timer #(
    parameter int W = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic active,
    input  logic mem_ready,
    output logic expired
);
    localparam logic [W-1:0] LIMIT = {W{1'b1}};
    logic [W-1:0] cnt_q, cnt_d;
    logic         stall;
    assign stall   = active && !mem_ready;
    // the cycle whose stall would take the count to LIMIT is the expiring one
    assign expired = stall && cnt_q == LIMIT - W'(1);
    always_comb begin
        cnt_d = clr ? '0 : (stall && cnt_q != LIMIT) ? cnt_q + W'(1) : cnt_q;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FETCH/DECODE/EXEC/MEM/WB sequencer with memory timeout and retire counter.
// Defining CTRL_BEQ_EN adds the BEQ instruction (opcode 0101); otherwise it decodes as illegal.
module multicycle_ctrl import ctrl_pkg::*; #(
    parameter int OPCODE_W  = 4,
    parameter int ALUOP_W   = 3,
    parameter int TIMEOUT_W = 4,
    parameter int RETIRE_W  = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                alu_zero,
    output logic                instrFetch,
    output logic                irLoad,
    output logic                pcInc,
    output logic                jump,
    output logic                regWrite,
    output logic                memRead,
    output logic                memWrite,
    output logic [ALUOP_W-1:0]  aluOp,
    output logic                busy,
    output logic                illegal,
    output logic                timeout_err,
    output logic [RETIRE_W-1:0] retired
);
    state_e                state_q, state_d;
    logic [OPCODE_W-1:0]   op_q, op_d;
    logic [RETIRE_W-1:0]   retired_q, retired_d;
    logic                  timeout_q, timeout_d;
    logic                  waiting, wait_clr, expired, retire, done;
    logic                  is_add, is_sub, is_load, is_store, is_jump, is_beq, is_alu, is_mem;

    assign is_add   = op_q == OPCODE_W'(OP_ADD);
    assign is_sub   = op_q == OPCODE_W'(OP_SUB);
    assign is_load  = op_q == OPCODE_W'(OP_LOAD);
    assign is_store = op_q == OPCODE_W'(OP_STORE);
    assign is_jump  = op_q == OPCODE_W'(OP_JUMP);
    assign is_alu   = is_add || is_sub;
    assign is_mem   = is_load || is_store;
`ifdef CTRL_BEQ_EN
    assign is_beq   = op_q == OPCODE_W'(OP_BEQ);
`else
    logic unused_alu_zero;
    assign unused_alu_zero = alu_zero;
    assign is_beq   = 1'b0;
`endif

    // counter restarts whenever FETCH or MEM is freshly entered
    assign waiting  = state_q == S_FETCH || state_q == S_MEM;
    assign wait_clr = (state_d == S_FETCH || state_d == S_MEM) && state_d != state_q;

    ctrl_wait_timer #(.W(TIMEOUT_W)) u_timer (
        .clk       (clk),
        .reset     (reset),
        .clr       (wait_clr),
        .active    (waiting),
        .mem_ready (mem_ready),
        .expired   (expired)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        timeout_d  = timeout_q;
        retire     = 1'b0;
        done       = 1'b0;
        instrFetch = 1'b0;
        irLoad     = 1'b0;
        pcInc      = 1'b0;
        jump       = 1'b0;
        regWrite   = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        illegal    = 1'b0;
        aluOp      = ALUOP_W'(ALU_ADD);
        case (state_q)
            S_IDLE: state_d = (run && !timeout_q) ? S_FETCH : S_IDLE;
            S_FETCH: begin
                instrFetch = 1'b1;
                irLoad     = mem_ready;
                pcInc      = mem_ready;
                state_d    = mem_ready ? S_DECODE : expired ? S_IDLE : S_FETCH;
                timeout_d  = timeout_q || expired;
            end
            S_DECODE: begin
                op_d    = opcode;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                aluOp   = (is_sub || is_beq) ? ALUOP_W'(ALU_SUB) : ALUOP_W'(ALU_ADD);
                jump    = is_jump || (is_beq && alu_zero);
                illegal = !(is_alu || is_mem || is_jump || is_beq);
                retire  = is_jump || is_beq;
                done    = !(is_alu || is_mem);
                state_d = is_alu ? S_WB : S_MEM;
            end
            S_MEM: begin
                memRead   = is_load;
                memWrite  = is_store;
                retire    = mem_ready && is_store;
                done      = mem_ready && is_store;
                state_d   = mem_ready ? S_WB : expired ? S_IDLE : S_MEM;
                timeout_d = timeout_q || expired;
            end
            S_WB: begin
                regWrite = 1'b1;
                retire   = 1'b1;
                done     = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
        // instruction boundary: run only matters here, never mid-instruction
        if (done) state_d = run ? S_FETCH : S_IDLE;
        retired_d = retired_q + RETIRE_W'(retire);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            retired_q <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            retired_q <= retired_d;
            timeout_q <= timeout_d;
        end
    end

    assign busy        = state_q != S_IDLE;
    assign timeout_err = timeout_q;
    assign retired     = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: random instruction stream checked against a per-instruction waveform model.
module tb_multicycle_ctrl;
    localparam int TW     = 3;
    localparam int TO_LIM = (1 << TW) - 1;
    localparam int RW     = 4;
`ifdef CTRL_BEQ_EN
    localparam bit BEQ_EN = 1'b1;
`else
    localparam bit BEQ_EN = 1'b0;
`endif

    typedef struct packed {
        logic       fetch, irl, pci, jmp, rw, mr, mw;
        logic [2:0] alu;
        logic       busy, ill, to;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b1, run = 1'b0, mem_ready = 1'b0, alu_zero = 1'b0;
    logic [3:0]  opcode = 4'd0;
    logic        instrFetch, irLoad, pcInc, jump, regWrite, memRead, memWrite;
    logic [2:0]  aluOp;
    logic        busy, illegal, timeout_err;
    logic [RW-1:0] retired;
    logic [12:0] got;
    int          n_tests = 0, n_fail = 0, exp_ret = 0;
    bit          exp_to = 1'b0, idle = 1'b1;

    always #5 clk = ~clk;

    multicycle_ctrl #(.OPCODE_W(4), .ALUOP_W(3), .TIMEOUT_W(TW), .RETIRE_W(RW)) dut (
        .clk(clk), .reset(reset), .run(run), .opcode(opcode), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .instrFetch(instrFetch), .irLoad(irLoad), .pcInc(pcInc),
        .jump(jump), .regWrite(regWrite), .memRead(memRead), .memWrite(memWrite),
        .aluOp(aluOp), .busy(busy), .illegal(illegal), .timeout_err(timeout_err),
        .retired(retired)
    );

    assign got = {instrFetch, irLoad, pcInc, jump, regWrite, memRead, memWrite,
                  aluOp, busy, illegal, timeout_err};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    function automatic exp_t idle_e();
        idle_e    = '0;
        idle_e.to = exp_to;
    endfunction

    function automatic exp_t busy_e();
        busy_e      = '0;
        busy_e.busy = 1'b1;
        busy_e.to   = exp_to;
    endfunction

    task automatic cyc(input logic rdy, input logic rn, input exp_t e);
        mem_ready = rdy;
        run       = rn;
        @(negedge clk);
        check("outputs", 32'(got), 32'(e));
        check("retired", 32'(retired), 32'(exp_ret));
        @(posedge clk);
        #1;
    endtask

    task automatic bump();
        exp_ret = (exp_ret + 1) % (1 << RW);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset   = 1'b0;
        exp_ret = 0;
        exp_to  = 1'b0;
        idle    = 1'b1;
    endtask

    // fw/mw: stall cycles before mem_ready; >= TO_LIM means memory never answers
    task automatic do_instr(input logic [3:0] op, input int fw, input int mw,
                            input logic az, input logic run_end, input bit rst_mem);
        exp_t e;
        bit   alu_i, mem_i, jmp_i, beq_i, ends;
        opcode   = op;
        alu_zero = az;
        alu_i = op < 4'd2;
        mem_i = op == 4'd2 || op == 4'd3;
        jmp_i = op == 4'd4;
        beq_i = BEQ_EN && op == 4'd5;
        if (idle) begin
            repeat ($urandom_range(0, 2)) cyc(1'($urandom), 1'b0, idle_e());
            cyc(1'($urandom), 1'b1, idle_e());
            idle = 1'b0;
        end
        for (int k = 0; k <= fw && k < TO_LIM; k++) begin
            e = busy_e();
            e.fetch = 1'b1;
            e.irl   = k == fw;
            e.pci   = k == fw;
            cyc(k == fw, 1'($urandom), e);
        end
        if (fw >= TO_LIM) begin
            exp_to = 1'b1;
            idle   = 1'b1;
            return;
        end
        cyc(1'($urandom), 1'($urandom), busy_e());
        e = busy_e();
        e.alu = (op == 4'd1 || beq_i) ? 3'd1 : 3'd0;
        e.jmp = jmp_i || (beq_i && az);
        e.ill = !(alu_i || mem_i || jmp_i || beq_i);
        ends  = !(alu_i || mem_i);
        cyc(1'($urandom), ends ? run_end : 1'($urandom), e);
        if (jmp_i || beq_i) bump();
        if (mem_i) begin
            for (int k = 0; k <= mw && k < TO_LIM; k++) begin
                e = busy_e();
                e.mr = op == 4'd2;
                e.mw = op == 4'd3;
                reset = rst_mem;
                cyc(k == mw, (k == mw && op == 4'd3) ? run_end : 1'($urandom), e);
                if (rst_mem) begin
                    reset   = 1'b0;
                    exp_ret = 0;
                    exp_to  = 1'b0;
                    idle    = 1'b1;
                    return;
                end
            end
            if (mw >= TO_LIM) begin
                exp_to = 1'b1;
                idle   = 1'b1;
                return;
            end
            if (op == 4'd3) bump();
        end
        if (alu_i || op == 4'd2) begin
            e = busy_e();
            e.rw = 1'b1;
            cyc(1'($urandom), run_end, e);
            bump();
        end
        idle = !ends || !e.ill ? !run_end : !run_end;
    endtask

    initial begin
        int r;
        logic [3:0] op;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0, idle_e());
        do_instr(4'd0, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(4'd2, 0, 3, 1'b0, 1'b1, 1'b0);
        do_instr(4'd15, 0, 0, 1'b0, 1'b1, 1'b0);
        do_instr(4'd1, 1, 0, 1'b0, 1'b0, 1'b0);
        do_instr(4'd3, 0, TO_LIM - 1, 1'b0, 1'b1, 1'b0);
        do_instr(4'd4, TO_LIM - 1, 0, 1'b0, 1'b1, 1'b0);
        do_instr(4'd5, 0, 0, 1'b1, 1'b1, 1'b0);
        do_instr(4'd5, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            r  = $urandom_range(0, 7);
            op = r < 6 ? 4'(r) : 4'($urandom_range(6, 15));
            do_instr(op, $urandom_range(0, 3) == 0 ? TO_LIM - 1 : $urandom_range(0, 2),
                     $urandom_range(0, 3) == 0 ? TO_LIM - 1 : $urandom_range(0, 2),
                     1'($urandom), $urandom_range(0, 3) != 0, 1'b0);
        end
        do_instr(4'd3, 0, 2, 1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, idle_e());
        do_instr(4'd0, TO_LIM, 0, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'($urandom), 1'b1, idle_e());
        do_reset();
        cyc(1'b0, 1'b1, idle_e());
        idle = 1'b0;
        do_instr(4'd2, 0, TO_LIM, 1'b0, 1'b1, 1'b0);
        repeat (3) cyc(1'($urandom), 1'b1, idle_e());
        do_reset();
        cyc(1'b0, 1'b0, idle_e());
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
